hs_matmul: RTL and testbench

- Downstream consumer of the H/S matrix loader stage.
- Captures streamed 4x4 complex matrices H and S, each element as signed DW-bit real and imaginary parts.
- On a start pulse (the loader's done strobe), computes Y = H x S with one time-shared complex MAC.
- Emits the 16 Y elements in row-major order over a valid/ready handshake.

---
 rtl/hs_matmul.sv | 198 +++++++++++++++++++
 tb/tb_hs_matmul.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_matmul.sv
// 4x4 complex H x S matrix multiply, one time-shared complex MAC, streamed Y output.
// Define HS_MATMUL_ROUND_EN to round half up before the output shift.
module hs_matmul #(
  parameter int DW   = 16,
  parameter int FRAC = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_sel,
  input  logic [3:0]    in_addr,
  input  logic [DW-1:0] in_real,
  input  logic [DW-1:0] in_im,
  input  logic          start,
  input  logic          y_ready,
  output logic          y_valid,
  output logic [3:0]    y_addr,
  output logic [DW-1:0] y_real,
  output logic [DW-1:0] y_im,
  output logic          busy,
  output logic          done
);

  localparam int PW = 2 * DW;
  localparam int AW = 2 * DW + 2;
  localparam logic signed [AW:0] SMAX =
    {{(AW-DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW:0] SMIN =
    {{(AW-DW+2){1'b1}}, {(DW-1){1'b0}}};
`ifdef HS_MATMUL_ROUND_EN
  localparam logic signed [AW:0] RND =
    {{(AW-FRAC+1){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
`endif

  typedef enum logic [1:0] {IDLE, COMPUTE, OUT, DONE} state_e;

  state_e state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [1:0] k_q, k_d;
  logic signed [AW-1:0] acc_re_q, acc_re_d;
  logic signed [AW-1:0] acc_im_q, acc_im_d;
  logic y_valid_q, y_valid_d;
  logic [3:0] y_addr_q, y_addr_d;
  logic [DW-1:0] y_re_q, y_re_d;
  logic [DW-1:0] y_im_q, y_im_d;
  logic done_q, done_d;

  logic signed [DW-1:0] h_re_q [16];
  logic signed [DW-1:0] h_im_q [16];
  logic signed [DW-1:0] s_re_q [16];
  logic signed [DW-1:0] s_im_q [16];

  logic signed [DW-1:0] h_r, h_i, s_r, s_i;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [AW-1:0] sum_re, sum_im;
  logic wr_en;

  function automatic logic [DW-1:0] sat_fn(
    input logic signed [AW-1:0] a
  );
    logic signed [AW:0] r;
    logic signed [AW:0] sh;
    r = {a[AW-1], a};
`ifdef HS_MATMUL_ROUND_EN
    r = r + RND;
`endif
    sh = r >>> FRAC;
    if (sh > SMAX)
      return SMAX[DW-1:0];
    else if (sh < SMIN)
      return SMIN[DW-1:0];
    else
      return sh[DW-1:0];
  endfunction

  assign wr_en = in_valid && (state_q == IDLE);

  // H walks row i, S walks column j
  assign h_r = h_re_q[{idx_q[3:2], k_q}];
  assign h_i = h_im_q[{idx_q[3:2], k_q}];
  assign s_r = s_re_q[{k_q, idx_q[1:0]}];
  assign s_i = s_im_q[{k_q, idx_q[1:0]}];

  assign p_rr = PW'(h_r) * PW'(s_r);
  assign p_ii = PW'(h_i) * PW'(s_i);
  assign p_ri = PW'(h_r) * PW'(s_i);
  assign p_ir = PW'(h_i) * PW'(s_r);

  assign sum_re = acc_re_q + AW'(p_rr) - AW'(p_ii);
  assign sum_im = acc_im_q + AW'(p_ri) + AW'(p_ir);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    k_d       = k_q;
    acc_re_d  = acc_re_q;
    acc_im_d  = acc_im_q;
    y_valid_d = y_valid_q;
    y_addr_d  = y_addr_q;
    y_re_d    = y_re_q;
    y_im_d    = y_im_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = COMPUTE;
          idx_d    = '0;
          k_d      = '0;
          acc_re_d = '0;
          acc_im_d = '0;
        end
      end
      COMPUTE: begin
        acc_re_d = sum_re;
        acc_im_d = sum_im;
        k_d      = k_q + 2'd1;
        if (k_q == 2'd3) begin
          state_d   = OUT;
          y_valid_d = 1'b1;
          y_addr_d  = idx_q;
          y_re_d    = sat_fn(sum_re);
          y_im_d    = sat_fn(sum_im);
        end
      end
      OUT: begin
        if (y_ready) begin
          y_valid_d = 1'b0;
          acc_re_d  = '0;
          acc_im_d  = '0;
          k_d       = '0;
          if (idx_q == 4'd15) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = COMPUTE;
            idx_d   = idx_q + 4'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      k_q       <= '0;
      acc_re_q  <= '0;
      acc_im_q  <= '0;
      y_valid_q <= 1'b0;
      y_addr_q  <= '0;
      y_re_q    <= '0;
      y_im_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      k_q       <= k_d;
      acc_re_q  <= acc_re_d;
      acc_im_q  <= acc_im_d;
      y_valid_q <= y_valid_d;
      y_addr_q  <= y_addr_d;
      y_re_q    <= y_re_d;
      y_im_q    <= y_im_d;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < 16; n++) begin
        h_re_q[n] <= '0;
        h_im_q[n] <= '0;
        s_re_q[n] <= '0;
        s_im_q[n] <= '0;
      end
    end else if (wr_en) begin
      if (in_sel) begin
        s_re_q[in_addr] <= in_real;
        s_im_q[in_addr] <= in_im;
      end else begin
        h_re_q[in_addr] <= in_real;
        h_im_q[in_addr] <= in_im;
      end
    end
  end

  assign y_valid = y_valid_q;
  assign y_addr  = y_addr_q;
  assign y_real  = y_re_q;
  assign y_im    = y_im_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_hs_matmul.sv
// Randomized bench for hs_matmul against a plain-arithmetic matrix product model.
// Honours HS_MATMUL_ROUND_EN the same way the design does.
module tb_hs_matmul;

  localparam int DW   = 16;
  localparam int FRAC = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sel = 1'b0;
  logic [3:0]    in_addr = '0;
  logic [DW-1:0] in_real = '0;
  logic [DW-1:0] in_im = '0;
  logic          start = 1'b0;
  logic          y_ready = 1'b0;
  logic          y_valid;
  logic [3:0]    y_addr;
  logic [DW-1:0] y_real;
  logic [DW-1:0] y_im;
  logic          busy;
  logic          done;

  hs_matmul #(.DW(DW), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_sel(in_sel), .in_addr(in_addr),
    .in_real(in_real), .in_im(in_im),
    .start(start), .y_ready(y_ready),
    .y_valid(y_valid), .y_addr(y_addr),
    .y_real(y_real), .y_im(y_im),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad = 0;

  longint mhr [16], mhi [16], msr [16], msi [16];
  longint exp_re [16], exp_im [16];
  longint got_re [16], got_im [16];
  int first_v [16], hs [16];
  int exp_idx = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  bit seen_v = 0;

  task automatic chk(input string nm, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  function automatic longint sx16(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint scale(input longint acc);
    longint a;
    a = acc;
`ifdef HS_MATMUL_ROUND_EN
    a = a + (longint'(1) << (FRAC - 1));
`endif
    a = a >>> FRAC;
    if (a > 32767) a = 32767;
    if (a < -32768) a = -32768;
    return a;
  endfunction

  task automatic compute_model();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        longint ar, ai;
        ar = 0;
        ai = 0;
        for (int k = 0; k < 4; k++) begin
          ar += mhr[i*4+k] * msr[k*4+j] - mhi[i*4+k] * msi[k*4+j];
          ai += mhr[i*4+k] * msi[k*4+j] + mhi[i*4+k] * msr[k*4+j];
        end
        exp_re[i*4+j] = scale(ar);
        exp_im[i*4+j] = scale(ai);
      end
  endtask

  // Single checker: every cycle Y is presented, it must match the model.
  always @(negedge clk) begin
    if (rst && y_valid) begin
      if (exp_idx > 15) begin
        chk("extra_y", exp_idx, 15);
      end else begin
        if (!seen_v) begin
          first_v[exp_idx] = cyc;
          seen_v = 1;
        end
        chk("y_addr", y_addr, exp_idx);
        chk("y_real", sx16(y_real), exp_re[exp_idx]);
        chk("y_im", sx16(y_im), exp_im[exp_idx]);
        if (y_ready) begin
          hs[exp_idx] = cyc;
          got_re[exp_idx] = sx16(y_real);
          got_im[exp_idx] = sx16(y_im);
          exp_idx++;
          seen_v = 0;
        end
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit sel, input int a, input longint re,
                    input longint im);
    in_valid = 1'b1;
    in_sel   = sel;
    in_addr  = a[3:0];
    in_real  = re[15:0];
    in_im    = im[15:0];
    if (sel) begin
      msr[a] = sx16(re[15:0]);
      msi[a] = sx16(im[15:0]);
    end else begin
      mhr[a] = sx16(re[15:0]);
      mhi[a] = sx16(im[15:0]);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic zero_all();
    for (int a = 0; a < 16; a++) begin
      wr(0, a, 0, 0);
      wr(1, a, 0, 0);
    end
  endtask

  function automatic longint rnd(input int mode);
    if (mode == 1) begin
      case ($urandom % 4)
        0: return 64'h7FFF;
        1: return 64'h8000;
        2: return 0;
        default: return longint'($urandom % 65536);
      endcase
    end
    return longint'($urandom % 65536);
  endfunction

  task automatic load_rand(input int mode);
    for (int a = 0; a < 16; a++) begin
      wr(0, a, rnd(mode), rnd(mode));
      wr(1, a, rnd(mode), rnd(mode));
    end
  endtask

  task automatic load_identity();
    for (int a = 0; a < 16; a++) begin
      wr(0, a, (a % 5 == 0) ? 64'h4000 : 0, 0);
      wr(1, a, a * 256, -a * 128);
    end
  endtask

  // bp: 0 = always ready, 1 = stall 3 cycles on element 5, 2 = random ready
  task automatic run(input int bp, input bit poke);
    int t0, bp_left;
    compute_model();
    exp_idx = 0;
    done_cnt = 0;
    seen_v = 0;
    bp_left = 3;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    chk("busy_compute", busy, 1);
    for (int c = 0; c < 500 && done_cnt == 0; c++) begin
      case (bp)
        1: begin
          if (y_valid && y_addr == 4'd5 && bp_left > 0) begin
            y_ready = 1'b0;
            bp_left--;
          end else begin
            y_ready = 1'b1;
          end
        end
        2: y_ready = ($urandom % 4) != 0;
        default: y_ready = 1'b1;
      endcase
      in_valid = poke && (cyc == t0 + 2);
      in_sel   = 1'b0;
      in_addr  = 4'd0;
      in_real  = 16'h1234;
      in_im    = 16'h4321;
      start    = poke && (cyc == t0 + 10);
      tick();
    end
    in_valid = 1'b0;
    start = 1'b0;
    y_ready = 1'b0;
    chk("done_seen", done_cnt, 1);
    chk("y_count", exp_idx, 16);
    chk("busy_after_done", busy, 0);
    chk("done_low_after", done, 0);
    if (bp == 0 && exp_idx == 16) begin
      chk("first_valid_lat", first_v[0] - t0, 5);
      chk("last_hs_lat", hs[15] - t0, 80);
      chk("done_lat", done_cyc - t0, 81);
    end
    if (bp == 1 && exp_idx == 16) begin
      chk("stall_len", hs[5] - first_v[5], 3);
      chk("next_after_stall", first_v[6] - hs[5], 5);
    end
    if (poke) begin
      repeat (10) tick();
      chk("no_restart", done_cnt, 1);
      chk("idle_after_poke", busy, 0);
    end
  endtask

  initial begin
    int t0;
    for (int a = 0; a < 16; a++) begin
      mhr[a] = 0; mhi[a] = 0; msr[a] = 0; msi[a] = 0;
    end
    repeat (2) tick();
    chk("rst_y_valid", y_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_y_real", y_real, 0);
    chk("rst_y_addr", y_addr, 0);
    rst = 1'b1;
    tick();

    load_identity();
    run(0, 0);
    chk("ident_re3", got_re[3], 768);
    chk("ident_im3", got_im[3], -384);
    chk("ident_re15", got_re[15], 3840);
    chk("ident_im15", got_im[15], -1920);

    zero_all();
    wr(0, 0, 0, 64'h4000);
    wr(1, 0, 64'h4000, 0);
    run(0, 0);
    chk("cplx_re0", got_re[0], 0);
    chk("cplx_im0", got_im[0], 16384);
    chk("cplx_re5", got_re[5], 0);

    for (int a = 0; a < 16; a++) begin
      wr(0, a, 64'h7FFF, 0);
      wr(1, a, 64'h7FFF, 0);
    end
    run(0, 0);
    chk("satp_re0", got_re[0], 32767);
    chk("satp_im9", got_im[9], 0);
    for (int a = 0; a < 16; a++) wr(0, a, 64'h8000, 0);
    run(0, 0);
    chk("satn_re4", got_re[4], -32768);

    load_rand(0);
    run(1, 0);
    run(0, 1);

    for (int r = 0; r < 4; r++) begin
      load_rand(r % 2);
      run((r < 2) ? 2 : 0, 0);
    end

    zero_all();
    wr(0, 0, 1, 0);
    wr(1, 0, 64'h2000, 0);
    run(0, 0);
`ifdef HS_MATMUL_ROUND_EN
    chk("round_re0", got_re[0], 1);
`else
    chk("round_re0", got_re[0], 0);
`endif

    load_identity();
    done_cnt = 0;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", y_valid, 0);
    chk("midrst_done", done, 0);
    chk("midrst_real", y_real, 0);
    for (int a = 0; a < 16; a++) begin
      mhr[a] = 0; mhi[a] = 0; msr[a] = 0; msi[a] = 0;
    end
    tick();
    tick();
    rst = 1'b1;
    repeat (5) tick();
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_idle", busy, 0);
    run(0, 0);
    chk("cleared_re7", got_re[7], 0);
    load_identity();
    run(0, 0);
    chk("reload_re9", got_re[9], 2304);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
